// File: rtl/calc_command_scheduler_pkg.sv
// Shared opcodes, FSM encoding and default parameters for the calculator
// command scheduler.
package calc_command_scheduler_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 10;
  localparam int DEFAULT_QUEUE_DEPTH  = 4;
  localparam int DEFAULT_DONE_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage

// File: rtl/calc_command_scheduler_if.sv
// Key-event, command and status bundle between the keypad/calculator side
// (master) and the scheduler (slave).
interface calc_command_scheduler_if #(
  parameter int DATA_WIDTH  = calc_command_scheduler_pkg::DEFAULT_DATA_WIDTH,
  parameter int QUEUE_DEPTH = calc_command_scheduler_pkg::DEFAULT_QUEUE_DEPTH
);
  import calc_command_scheduler_pkg::*;

  logic                           key_add;
  logic                           key_sub;
  logic                           key_clear;
  logic [DATA_WIDTH-1:0]          calc_data;
  logic                           cmd_done;
  logic                           cmd_clear;
  logic                           cmd_compute;
  logic                           cmd_operation;
  logic [DATA_WIDTH-1:0]          cmd_data;
  logic                           busy;
  logic [$clog2(QUEUE_DEPTH):0]   queue_count;
  logic                           drop;
  logic                           timeout_err;

  modport master (
    output key_add, key_sub, key_clear, calc_data, cmd_done,
    input  cmd_clear, cmd_compute, cmd_operation, cmd_data,
           busy, queue_count, drop, timeout_err
  );

  modport slave (
    input  key_add, key_sub, key_clear, calc_data, cmd_done,
    output cmd_clear, cmd_compute, cmd_operation, cmd_data,
           busy, queue_count, drop, timeout_err
  );

endinterface

// File: rtl/calc_command_scheduler_cmd_queue_fifo.sv
// Power-of-two command FIFO with flush; a push during flush lands in slot 0
// so a CLEAR leaves exactly one entry behind.
module cmd_queue_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && (!full || pop || flush);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[flush ? '0 : wr_ptr] <= push_data;
  end

endmodule

// File: rtl/calc_command_scheduler.sv
// Turns keypad events into queued calculator commands and issues them one at
// a time, waiting for completion or a timeout.
module calc_command_scheduler
  import calc_command_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH,
  parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  calc_command_scheduler_if.slave  bus
);

  localparam int EW = DATA_WIDTH + 2;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int TW = $clog2(DONE_TIMEOUT) + 1;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  opcode_t               evt_op;
  logic                  evt_drop;
  logic                  push, pop, flush, full, empty;
  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  opcode_t               head_op;
  logic                  expired;

  // One event per cycle: CLEAR beats SUB beats ADD, losers are dropped.
  always_comb begin
    evt_op   = OP_NONE;
    evt_drop = 1'b0;
    if (bus.key_clear) begin
      evt_op   = OP_CLR;
      evt_drop = bus.key_sub || bus.key_add;
    end else if (bus.key_sub) begin
      evt_op   = OP_SUB;
      evt_drop = bus.key_add;
    end else if (bus.key_add) begin
      evt_op   = OP_ADD;
    end
  end

  assign pop     = !reset && (state_q == ST_ISSUE) && !empty;
  assign flush   = !reset && (evt_op == OP_CLR);
  assign push    = !reset && (evt_op != OP_NONE) && ((evt_op == OP_CLR) || !full || pop);
  assign head_op = opcode_t'(head[EW-1 -: 2]);
  assign expired = (timer_q == TW'(DONE_TIMEOUT - 1));

  cmd_queue_fifo #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({evt_op, bus.calc_data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.cmd_done || expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A done pulse on the expiry cycle wins, so no error is flagged then.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          timer_q <= '0;
          data_q  <= head[DATA_WIDTH-1:0];
          if (head_op == OP_CLR) err_q <= 1'b0;
        end
        ST_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (expired && !bus.cmd_done) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes and operand come straight from the queue head during ISSUE.
  always_comb begin
    bus.cmd_clear     = 1'b0;
    bus.cmd_compute   = 1'b0;
    bus.cmd_operation = 1'b0;
    bus.cmd_data      = reset ? '0 : data_q;
    if (!reset && state_q == ST_ISSUE) begin
      bus.cmd_data      = head[DATA_WIDTH-1:0];
      bus.cmd_clear     = (head_op == OP_CLR);
      bus.cmd_compute   = (head_op == OP_ADD) || (head_op == OP_SUB);
      bus.cmd_operation = (head_op == OP_SUB);
    end
  end

  assign bus.busy        = !reset && ((state_q != ST_IDLE) || !empty);
  assign bus.queue_count = reset ? '0 : count;
  assign bus.timeout_err = !reset && err_q;
  assign bus.drop        = !reset && (evt_drop ||
                           (((evt_op == OP_ADD) || (evt_op == OP_SUB)) && full && !pop));

endmodule

// File: tb/tb_calc_command_scheduler.sv
// Directed bench: expected strobes go into a scoreboard queue that a monitor
// drains whenever the scheduler issues a command.
module tb_calc_command_scheduler;
  import calc_command_scheduler_pkg::*;

  localparam int DW = 10;
  localparam int QD = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic          clear;
    logic          compute;
    logic          op;
    logic [DW-1:0] data;
  } cmd_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  cmd_exp_t exp_q[$];

  calc_command_scheduler_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) bus ();

  calc_command_scheduler #(
    .DATA_WIDTH   (DW),
    .QUEUE_DEPTH  (QD),
    .DONE_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: bound expired, got no response, expected one", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic add, input logic sub, input logic clr, input logic [DW-1:0] data);
    bus.key_add   = add;
    bus.key_sub   = sub;
    bus.key_clear = clr;
    bus.calc_data = data;
  endtask

  task automatic expectCmd(input opcode_t op, input logic [DW-1:0] data);
    cmd_exp_t e;
    e.clear   = (op == OP_CLR);
    e.compute = (op == OP_ADD) || (op == OP_SUB);
    e.op      = (op == OP_SUB);
    e.data    = data;
    exp_q.push_back(e);
  endtask

  task automatic pulseDone();
    bus.cmd_done = 1'b1;
    step();
    bus.cmd_done = 1'b0;
  endtask

  // Waits for the next strobe, then completes that command in its first WAIT cycle.
  task automatic serviceOne(input string name);
    int n = 0;
    @(negedge clk);
    while (!(bus.cmd_clear || bus.cmd_compute) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) reportTimeout(name);
    step();
    pulseDone();
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) reportTimeout(name);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_clear"},   32'(bus.cmd_clear),   0);
    checkOutput({tag, "_cmd_compute"}, 32'(bus.cmd_compute), 0);
    checkOutput({tag, "_cmd_op"},      32'(bus.cmd_operation), 0);
    checkOutput({tag, "_cmd_data"},    32'(bus.cmd_data),    0);
    checkOutput({tag, "_busy"},        32'(bus.busy),        0);
    checkOutput({tag, "_queue_count"}, 32'(bus.queue_count), 0);
    checkOutput({tag, "_drop"},        32'(bus.drop),        0);
    checkOutput({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected command.
  always @(negedge clk) begin
    if (!reset && (bus.cmd_clear || bus.cmd_compute)) begin
      checkOutput("strobe_exclusive", 32'(bus.cmd_clear && bus.cmd_compute), 0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_strobe: got clear=%0b compute=%0b data=%0h, expected none",
                 bus.cmd_clear, bus.cmd_compute, bus.cmd_data);
      end else begin
        cmd_exp_t e;
        e = exp_q.pop_front();
        checkOutput("strobe", 32'({bus.cmd_clear, bus.cmd_compute, bus.cmd_operation, bus.cmd_data}), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(0, 0, 0, '0);
    bus.cmd_done = 1'b0;

    // Reset: outputs zero, key during reset discarded silently.
    step();
    step();
    applyStimulus(1, 0, 0, 10'd77);
    @(negedge clk);
    checkAllZero("reset");
    step();
    applyStimulus(0, 0, 0, '0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_key_discarded", 32'(bus.queue_count), 0);
    checkOutput("reset_busy_after", 32'(bus.busy), 0);

    // Single ADD: strobe two cycles after the key, BUSY drops after done.
    step();
    applyStimulus(1, 0, 0, 10'd5);
    expectCmd(OP_ADD, 10'd5);
    @(negedge clk);
    checkOutput("add_drop", 32'(bus.drop), 0);
    step();
    applyStimulus(0, 0, 0, '0);
    @(negedge clk);
    checkOutput("add_n1_compute", 32'(bus.cmd_compute), 0);
    checkOutput("add_n1_count", 32'(bus.queue_count), 1);
    step();
    @(negedge clk);
    checkOutput("add_n2_compute", 32'(bus.cmd_compute), 1);
    checkOutput("add_n2_op", 32'(bus.cmd_operation), 0);
    checkOutput("add_n2_data", 32'(bus.cmd_data), 5);
    step();
    @(negedge clk);
    checkOutput("add_n3_data_held", 32'(bus.cmd_data), 5);
    step();
    step();
    bus.cmd_done = 1'b1;
    @(negedge clk);
    checkOutput("add_n5_busy", 32'(bus.busy), 1);
    step();
    bus.cmd_done = 1'b0;
    @(negedge clk);
    checkOutput("add_n6_busy", 32'(bus.busy), 0);

    // ADD and SUB together: SUB wins, one-cycle DROP.
    step();
    applyStimulus(1, 1, 0, 10'd7);
    expectCmd(OP_SUB, 10'd7);
    @(negedge clk);
    checkOutput("prio_drop", 32'(bus.drop), 1);
    step();
    applyStimulus(0, 0, 0, '0);
    @(negedge clk);
    checkOutput("prio_drop_cleared", 32'(bus.drop), 0);
    checkOutput("prio_count", 32'(bus.queue_count), 1);
    step();
    serviceOne("prio_service");
    waitIdle("prio_idle");

    // Queue fill while waiting: fifth event dropped, pop+push when full accepted.
    step();
    applyStimulus(1, 0, 0, 10'd1);
    expectCmd(OP_ADD, 10'd1);
    step();
    applyStimulus(0, 0, 0, '0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, DW'(2 + i));
      if (i < 4) expectCmd(OP_ADD, DW'(2 + i));
      @(negedge clk);
      if (i == 4) begin
        checkOutput("full_drop", 32'(bus.drop), 1);
        checkOutput("full_count", 32'(bus.queue_count), 4);
      end else begin
        checkOutput("fill_drop", 32'(bus.drop), 0);
      end
      step();
    end
    applyStimulus(0, 0, 0, '0);
    bus.cmd_done = 1'b1;
    @(negedge clk);
    checkOutput("full_count_hold", 32'(bus.queue_count), 4);
    checkOutput("full_drop_cleared", 32'(bus.drop), 0);
    step();
    bus.cmd_done = 1'b0;
    step();
    applyStimulus(1, 0, 0, 10'd9);
    expectCmd(OP_ADD, 10'd9);
    @(negedge clk);
    checkOutput("full_pop_push_drop", 32'(bus.drop), 0);
    checkOutput("full_pop_push_compute", 32'(bus.cmd_compute), 1);
    step();
    applyStimulus(0, 0, 0, '0);
    @(negedge clk);
    checkOutput("full_pop_push_count", 32'(bus.queue_count), 4);
    step();
    pulseDone();
    for (int i = 0; i < 4; i++) serviceOne("fill_service");
    waitIdle("fill_idle");

    // CLEAR flushes queued SUBs and becomes the only pending command.
    step();
    applyStimulus(1, 0, 0, 10'd20);
    expectCmd(OP_ADD, 10'd20);
    step();
    applyStimulus(0, 0, 0, '0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, DW'(21 + i));
      step();
    end
    applyStimulus(0, 0, 1, 10'h3FF);
    expectCmd(OP_CLR, 10'h3FF);
    @(negedge clk);
    checkOutput("clr_count_before", 32'(bus.queue_count), 3);
    checkOutput("clr_drop", 32'(bus.drop), 0);
    step();
    applyStimulus(0, 0, 0, '0);
    @(negedge clk);
    checkOutput("clr_count_after", 32'(bus.queue_count), 1);
    step();
    pulseDone();
    serviceOne("clr_service");
    waitIdle("clr_idle");

    // No done for DONE_TIMEOUT cycles: sticky error, cleared by next CLR issue.
    step();
    applyStimulus(1, 0, 0, 10'd30);
    expectCmd(OP_ADD, 10'd30);
    step();
    applyStimulus(0, 0, 0, '0);
    repeat (17) step();
    @(negedge clk);
    checkOutput("to_last_wait_err", 32'(bus.timeout_err), 0);
    checkOutput("to_last_wait_busy", 32'(bus.busy), 1);
    step();
    @(negedge clk);
    checkOutput("to_err_set", 32'(bus.timeout_err), 1);
    checkOutput("to_idle_busy", 32'(bus.busy), 0);
    step();
    applyStimulus(0, 0, 1, 10'd0);
    expectCmd(OP_CLR, 10'd0);
    step();
    applyStimulus(0, 0, 0, '0);
    step();
    step();
    @(negedge clk);
    checkOutput("to_err_cleared", 32'(bus.timeout_err), 0);
    step();
    pulseDone();
    waitIdle("to_idle");

    // Done on the expiry cycle is a normal completion; done while idle ignored.
    step();
    applyStimulus(1, 0, 0, 10'd40);
    expectCmd(OP_ADD, 10'd40);
    step();
    applyStimulus(0, 0, 0, '0);
    repeat (17) step();
    bus.cmd_done = 1'b1;
    step();
    bus.cmd_done = 1'b0;
    @(negedge clk);
    checkOutput("race_err", 32'(bus.timeout_err), 0);
    checkOutput("race_busy", 32'(bus.busy), 0);
    step();
    pulseDone();
    @(negedge clk);
    checkOutput("idle_done_busy", 32'(bus.busy), 0);
    checkOutput("idle_done_err", 32'(bus.timeout_err), 0);

    // Reset in WAIT with two queued entries: everything abandoned.
    step();
    applyStimulus(1, 0, 0, 10'd50);
    expectCmd(OP_ADD, 10'd50);
    step();
    applyStimulus(0, 0, 0, '0);
    step();
    step();
    applyStimulus(1, 0, 0, 10'd51);
    step();
    applyStimulus(1, 0, 0, 10'd52);
    step();
    applyStimulus(0, 1, 0, 10'd53);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    step();
    applyStimulus(0, 0, 0, '0);
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("postreset");
    step();
    pulseDone();
    @(negedge clk);
    checkOutput("postreset_done_busy", 32'(bus.busy), 0);
    checkOutput("postreset_done_err", 32'(bus.timeout_err), 0);
    repeat (6) step();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_command_scheduler.md
CALC_COMMAND_SCHEDULER -- requirements
Module: calc_command_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, operand width.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, command queue entries; power of two, at least 2.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1024, maximum cycles to wait for CMD_DONE.
REQ-004 CLK  in  1  system clock; all logic on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 KEY_ADD, KEY_SUB, KEY_CLEAR  in  1 each  single-cycle key event pulses.
REQ-007 CALC_DATA  in  DATA_WIDTH  debounced operand, sampled at key event.
REQ-008 CMD_DONE  in  1  calculator completion pulse.
REQ-009 CMD_CLEAR, CMD_COMPUTE  out  1 each  single-cycle command strobes.
REQ-010 CMD_OPERATION  out  1  0=add, 1=sub; valid while CMD_COMPUTE is high.
REQ-011 CMD_DATA  out  DATA_WIDTH  operand for the issued command; held from issue until completion.
REQ-012 BUSY  out  1  high while a command is outstanding or the queue is non-empty.
REQ-013 QUEUE_COUNT  out  clog2(QUEUE_DEPTH)+1  queue occupancy.
REQ-014 DROP  out  1  one-cycle pulse when a key event is discarded.
REQ-015 TIMEOUT_ERR  out  1  sticky flag: a command timed out.

Function
REQ-016 SHALL form at most one event per cycle. Priority is CLEAR > SUB > ADD. Each lower-priority event present in the same cycle SHALL be discarded with DROP=1.
REQ-017 SHALL encode each queue entry as {opcode[1:0], CALC_DATA}. Opcodes: ADD=01, SUB=10, CLR=11.
REQ-018 A CLEAR event SHALL flush all pending queue entries and leave the queue holding only the CLR entry. An outstanding command SHALL NOT be aborted.
REQ-019 An ADD/SUB event with the queue full and no pop in the same cycle SHALL be discarded with DROP=1. With a pop in the same cycle, the event SHALL be accepted.
REQ-020 Simultaneous push and pop SHALL leave QUEUE_COUNT unchanged. Pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-021 FSM states and transitions:
  - IDLE -> ISSUE when the queue is non-empty.
  - ISSUE (one cycle): pop the head; assert CMD_CLEAR (CLR) or CMD_COMPUTE with CMD_OPERATION (ADD/SUB); load CMD_DATA.
  - ISSUE -> WAIT.
  - WAIT -> IDLE on CMD_DONE.
  - WAIT -> IDLE when the timeout counter reaches DONE_TIMEOUT-1 without CMD_DONE; set TIMEOUT_ERR.
REQ-022 Latency: the event enqueued in cycle N into an empty queue with the FSM in IDLE SHALL produce its strobe in cycle N+2.
REQ-023 CMD_DONE received outside WAIT SHALL be ignored.
REQ-024 CMD_DONE and timeout expiry in the same cycle SHALL count as a normal completion, with no error.
REQ-025 TIMEOUT_ERR SHALL clear when a CLR command is issued or on RESET.
REQ-026 Only one command SHALL be outstanding at a time. CMD_CLEAR and CMD_COMPUTE SHALL never be high together.
REQ-027 The timeout counter SHALL reset to 0 on entry to WAIT.

Reset
REQ-028 While RESET is high, all outputs SHALL be 0:
  - CMD_CLEAR, CMD_COMPUTE, CMD_OPERATION, CMD_DATA=0;
  - BUSY, QUEUE_COUNT, DROP, TIMEOUT_ERR=0;
  - FSM=IDLE, queue empty.
REQ-029 RESET asserted mid-WAIT SHALL abandon the outstanding command with no strobe and no error. Key events during RESET SHALL be discarded without DROP.

Structure
REQ-030 The shared package SHALL hold the opcode constants (ADD/SUB/CLR), the FSM state encoding and the default parameter values.
REQ-031 The queue SHALL be a sub-module, cmd_queue_fifo, parameterised by width and depth, with push/pop/flush/full/empty/count ports.
REQ-032 The FSM, the event priority encoder and the timeout counter SHALL reside in calc_command_scheduler.

Verification
REQ-033 Idle, KEY_ADD with CALC_DATA=10'd5 in cycle N -> CMD_COMPUTE=1, CMD_OPERATION=0, CMD_DATA=5 in cycle N+2; CMD_DONE at N+5 -> BUSY=0 at N+6.
REQ-034 KEY_ADD and KEY_SUB in the same cycle -> a single SUB is issued; DROP=1 for one cycle.
REQ-035 Five ADD events while the first command waits for CMD_DONE (depth 4) -> QUEUE_COUNT saturates at 4; the fifth event gives DROP=1; four commands issue in order with their sampled operands.
REQ-036 Three SUBs queued, then KEY_CLEAR -> QUEUE_COUNT=1; the next strobe is CMD_CLEAR; the queued SUBs are never issued.
REQ-037 No CMD_DONE for DONE_TIMEOUT cycles -> TIMEOUT_ERR=1 and the FSM returns to IDLE; the next KEY_CLEAR issue -> TIMEOUT_ERR=0.
REQ-038 RESET pulsed during WAIT with two entries queued -> all outputs 0 next cycle; a later CMD_DONE is ignored.
